// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared segment constants, slot states and the hex-to-7-segment decoder
package hex_display_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic {GAP, DRIVE} slot_state_t;
  // active-low gfedcba patterns for hex digits 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex_decode(input logic [3:0] hex);
    return SEG_LUT[hex];
  endfunction
endpackage

// File: rtl/hex_scan_timer.sv
// hex_scan_timer: digit-slot timer, digit index, frame pulse and blink phase generator
module hex_scan_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_FRAMES = 64,
  localparam int TW = $clog2(REFRESH_DIV),
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1
) (
  input logic clk,
  input logic rst,
  output logic [TW-1:0] tick_cnt,
  output logic [IW-1:0] idx,
  output logic frame_done,
  output logic blink_phase
);
  logic [FW-1:0] frame_cnt;
  logic tick_last, idx_last, frame_last;
  always_comb begin
    tick_last = tick_cnt == TW'(REFRESH_DIV - 1);
    idx_last = idx == IW'(NUM_DIGITS - 1);
    frame_last = frame_cnt == FW'(BLINK_FRAMES - 1);
    frame_done = tick_last && idx_last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      idx <= '0;
      frame_cnt <= '0;
      blink_phase <= 1'b0;
    end else begin
      tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
      if (tick_last) idx <= idx_last ? '0 : idx + 1'b1;
      if (frame_done) begin
        frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
        if (frame_last) blink_phase <= ~blink_phase;
      end
    end
  end
endmodule

// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed common-anode 7-segment driver with blanking and blink
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic [4*NUM_DIGITS-1:0] data,
  input logic blank_lz,
  input logic blink_en,
  output logic [6:0] seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic frame_done
);
  localparam int TW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [TW-1:0] tick_cnt;
  logic [IW-1:0] idx;
  logic blink_phase;
  slot_state_t slot;
  logic [NUM_DIGITS-1:0] sel, lz, an_nxt;
  logic [3:0] nib;
  logic [6:0] seg_nxt;
  logic zero_above, off;
  hex_scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .tick_cnt(tick_cnt),
    .idx(idx),
    .frame_done(frame_done),
    .blink_phase(blink_phase)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow <= '0;
    else if (load) shadow <= data;
  end
  // lz[i] marks digits whose own and all higher nibbles are zero; digit 0 is never blanked
  always_comb begin
    lz = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && shadow[4*i +: 4] == 4'h0;
      lz[i] = zero_above;
    end
  end
  always_comb begin
    slot = tick_cnt == '0 ? GAP : DRIVE;
    sel = NUM_DIGITS'(1) << idx;
    nib = 4'(shadow >> (4 * idx));
    off = slot == GAP || (blink_en && blink_phase) || (blank_lz && |(lz & sel));
    seg_nxt = off ? SEG_BLANK : hex_decode(nib);
    an_nxt = off ? '1 : ~sel;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
      an <= '1;
    end else begin
      seg <= seg_nxt;
      an <= an_nxt;
    end
  end
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner: directed and random checks against an arithmetic scan model
module tb_hex_display_scanner;
  localparam int N = 4;
  localparam int R = 4;
  localparam int BF = 2;
  logic clk = 0, rst = 0, load = 0, blank_lz = 0, blink_en = 0;
  logic [15:0] data = '0;
  logic [6:0] seg;
  logic [3:0] an;
  logic frame_done;
  int n_assert = 0, n_fail = 0, k = 0, tk, ix;
  logic off;
  logic [15:0] m_shadow = '0;
  logic [6:0] exp_seg = 7'h7F;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] segs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .blank_lz(blank_lz),
    .blink_en(blink_en), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (k=%0d, t=%0t)", nm, act, expv, k, $time);
    end
  endtask

  // Model: k = clock edges since reset release; state k drives the outputs seen in cycle k+1
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_fd", 32'(frame_done), 32'h0);
      k = 0;
      m_shadow = '0;
      exp_seg = 7'h7F;
      exp_an = 4'hF;
    end else begin
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("an", 32'(an), 32'(exp_an));
      chk("frame_done", 32'(frame_done), 32'(k % (R * N) == R * N - 1));
      chk("an_onehot", 32'($countones(~an) <= 1), 32'h1);
      chk("blank_seg", 32'(an != 4'hF || seg == 7'h7F), 32'h1);
      tk = k % R;
      ix = (k / R) % N;
      off = tk == 0 || (blink_en && (k / (R * N * BF)) % 2 == 1) ||
            (blank_lz && ix > 0 && (m_shadow >> (4 * ix)) == 16'h0);
      exp_an = off ? 4'hF : ~(4'b1 << ix);
      exp_seg = off ? 7'h7F : segs[4'(m_shadow >> (4 * ix))];
      if (load) m_shadow = data;
      k++;
    end
  end

  task automatic to_cycle(input int c);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (k != c && n < 400);
    if (k != c) chk("to_cycle_reach", 32'(k), 32'(c));
  endtask

  task automatic lit(input string nm, input int c, input logic [3:0] ea, input logic [6:0] es, input logic efd);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while (k != c + 1 && n < 400);
    if (k != c + 1) chk({nm, "_reach"}, 32'(k), 32'(c + 1));
    else begin
      chk({nm, "_an"}, 32'(an), 32'(ea));
      chk({nm, "_seg"}, 32'(seg), 32'(es));
      chk({nm, "_fd"}, 32'(frame_done), 32'(efd));
    end
  endtask

  initial begin
    #1 rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_fd", 32'(frame_done), 32'h0);
    @(posedge clk); #1;
    rst = 0; load = 1; data = 16'h1234;
    to_cycle(1); load = 0;
    lit("d0_1234", 2, 4'hE, 7'h19, 0);
    lit("gap_1234", 5, 4'hF, 7'h7F, 0);
    lit("d1_1234", 6, 4'hD, 7'h30, 0);
    lit("d2_1234", 10, 4'hB, 7'h24, 0);
    lit("d3_1234", 14, 4'h7, 7'h79, 0);
    lit("fd_1234", 15, 4'h7, 7'h79, 1);
    to_cycle(16); load = 1; data = 16'h00A5; blank_lz = 1;
    to_cycle(17); load = 0;
    lit("lz_d0", 34, 4'hE, 7'h12, 0);
    lit("lz_d1", 38, 4'hD, 7'h08, 0);
    lit("lz_d2", 42, 4'hF, 7'h7F, 0);
    lit("lz_d3", 46, 4'hF, 7'h7F, 0);
    to_cycle(48); load = 1; data = 16'h0000;
    to_cycle(49); load = 0;
    lit("lz0_d0", 66, 4'hE, 7'h40, 0);
    lit("lz0_d1", 70, 4'hF, 7'h7F, 0);
    to_cycle(80); blank_lz = 0;
    to_cycle(89); load = 1; data = 16'hFFFF;
    to_cycle(90); load = 0;
    lit("ld_old", 90, 4'hB, 7'h40, 0);
    lit("ld_new", 91, 4'hB, 7'h0E, 0);
    lit("ld_d3", 94, 4'h7, 7'h0E, 0);
    to_cycle(96); blink_en = 1;
    lit("blink_off1", 98, 4'hF, 7'h7F, 0);
    lit("blink_on", 130, 4'hE, 7'h0E, 0);
    lit("blink_off2", 162, 4'hF, 7'h7F, 0);
    to_cycle(170); blink_en = 0;
    lit("unblink_pre", 170, 4'hF, 7'h7F, 0);
    lit("unblink", 171, 4'hB, 7'h0E, 0);
    to_cycle(190);
    chk("pre_rst_an", 32'(an), 32'h7);
    chk("pre_rst_seg", 32'(seg), 32'h0E);
    rst = 1;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_fd", 32'(frame_done), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    lit("post_rst0", 0, 4'hF, 7'h7F, 0);
    lit("post_rst_gap", 1, 4'hF, 7'h7F, 0);
    lit("post_rst_d0", 2, 4'hE, 7'h40, 0);
    for (int i = 0; i < 48; i++) begin
      @(posedge clk); #1;
      load = $urandom_range(0, 2) == 0;
      data = 16'($urandom) >> (4 * $urandom_range(0, 4));
      blank_lz = 1'($urandom_range(0, 1));
      blink_en = $urandom_range(0, 3) == 0;
    end
    @(posedge clk); #1;
    load = 0; blank_lz = 0; blink_en = 0;
    repeat (4) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
